// File: rtl/adder_32bit_sched.sv
// adder_32bit_sched: two-requester round-robin 32-bit adder built from one shared SLICE_W-bit slice
module adder_32bit_sched #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_sum,
  output logic        resp_cout,
  output logic        busy
);
  localparam int NSLICE = 32 / SLICE_W;

  if (SLICE_W != 8 && SLICE_W != 16) begin : g_bad_width
    $error("adder_32bit_sched: SLICE_W must be 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d, id_q, id_d, last_q, last_d;
  logic        grant1, accept;
  logic [SLICE_W:0] slice_res;

  // Operands shift right one slice per ADD cycle, so the shared adder always sees the low slice.
  assign slice_res = {1'b0, a_q[SLICE_W-1:0]} + {1'b0, b_q[SLICE_W-1:0]} + {{SLICE_W{1'b0}}, carry_q};

  // Round-robin grant: requester 1 wins when alone or when requester 0 was served last.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = (state_q == IDLE) && req0_valid && !grant1;
    req1_ready = (state_q == IDLE) && grant1;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  // Next-state: latch on accept, one slice per ADD cycle, hold in DONE until consumed.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    id_d    = id_q;
    last_d  = last_q;
    if (state_q == IDLE && accept) begin
      a_d     = grant1 ? req1_a : req0_a;
      b_d     = grant1 ? req1_b : req0_b;
      id_d    = grant1;
      sum_d   = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
      state_d = ADD;
    end
    if (state_q == ADD) begin
      a_d     = a_q >> SLICE_W;
      b_d     = b_q >> SLICE_W;
      sum_d   = {slice_res[SLICE_W-1:0], sum_q[31:SLICE_W]};
      carry_d = slice_res[SLICE_W];
      cnt_d   = cnt_q + 2'd1;
      state_d = (cnt_q == 2'(NSLICE - 1)) ? DONE : ADD;
    end
    if (state_q == DONE && resp_ready) begin
      state_d = IDLE;
      last_d  = id_q;
    end
  end

  // State registers; reset discards any operation and favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = carry_q;
endmodule

// File: tb/tb_adder_32bit_sched.sv
// tb_adder_32bit_sched: table-driven and scoreboarded checks of the scheduled adder
module tb_adder_32bit_sched;
  localparam int NSLICE = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, resp_ready = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, resp_valid, resp_id, resp_cout, busy;
  logic [31:0] resp_sum;

  logic w0_valid = 0, w1_valid = 0, w_resp_ready = 0;
  logic [31:0] w0_a = 0, w0_b = 0, w1_a = 0, w1_b = 0;
  logic w0_ready, w1_ready, w_resp_valid, w_resp_id, w_resp_cout, w_busy;
  logic [31:0] w_resp_sum;

  int tests = 0, fails = 0;

  typedef struct {
    logic v0; logic [31:0] a0, b0;
    logic v1; logic [31:0] a1, b1;
    logic id; logic [31:0] sum; logic cout;
  } vec_t;
  typedef struct { logic id; logic [31:0] sum; logic cout; } exp_t;

  exp_t sb[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  adder_32bit_sched #(.SLICE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy)
  );

  adder_32bit_sched #(.SLICE_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w0_valid), .req0_ready(w0_ready), .req0_a(w0_a), .req0_b(w0_b),
    .req1_valid(w1_valid), .req1_ready(w1_ready), .req1_a(w1_a), .req1_b(w1_b),
    .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_id(w_resp_id),
    .resp_sum(w_resp_sum), .resp_cout(w_resp_cout), .busy(w_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, resp_valid, 0);
    check({tag, "_id"}, resp_id, 0);
    check({tag, "_sum"}, resp_sum, 0);
    check({tag, "_cout"}, resp_cout, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    #1;
    check("ready0", req0_ready, !v.id);
    check("ready1", req1_ready, v.id);
    @(posedge clk);
    sb.push_back('{v.id, v.sum, v.cout});
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    check("busy_add", busy, 1);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
  endtask

  task automatic compare_resp;
    exp_t e;
    check("resp_valid", resp_valid, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("resp_id", resp_id, e.id);
      check("resp_sum", resp_sum, e.sum);
      check("resp_cout", resp_cout, e.cout);
    end
  endtask

  task automatic consume;
    resp_ready = 1;
    @(posedge clk); @(negedge clk);
    resp_ready = 0;
    check("idle_busy", busy, 0);
    check("idle_valid", resp_valid, 0);
  endtask

  task automatic run_op(input vec_t v);
    int n;
    start_op(v);
    wait_resp(n);
    check("latency", n, NSLICE);
    compare_resp();
    consume();
  endtask

  initial begin
    int n;
    logic [31:0] s;
    tbl[0] = '{1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0100, 1'b0};
    tbl[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 1'b1};
    tbl[2] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789, 1'b0};
    tbl[3] = '{1'b1, 32'd1, 32'd2, 1'b1, 32'd3, 32'd4, 1'b0, 32'd3, 1'b0};
    tbl[4] = '{1'b1, 32'd1, 32'd2, 1'b1, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0};
    tbl[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1};
    tbl[6] = '{1'b1, 32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 32'h5, 32'h6, 1'b0, 32'h0000_0000, 1'b1};
    tbl[7] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFE, 1'b0};

    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    @(negedge clk); rst_n = 0; #1; check_zero_outputs("rst2"); @(negedge clk); rst_n = 1;
    req0_valid = 1; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_a = 3; req1_b = 4;
    resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); @(negedge clk); n = 1; end else n = 0;
      while (!resp_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      check("rr_id", resp_id, i % 2);
      check("rr_sum", resp_sum, (i % 2) ? 7 : 3);
      check("rr_ready0", req0_ready, 0);
      check("rr_ready1", req1_ready, 0);
      if (i > 0) check("rr_spacing", n, NSLICE + 2);
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); @(negedge clk);
    resp_ready = 0;
    check("rr_idle", busy, 0);

    start_op('{1'b1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1010_1010, 1'b0});
    wait_resp(n);
    compare_resp();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_sum", resp_sum, 32'h1010_1010);
      check("hold_id", resp_id, 0);
      check("hold_rdy", {req0_ready, req1_ready}, 0);
    end
    req0_valid = 0; req1_valid = 0;
    consume();

    start_op('{1'b1, 32'd5, 32'd6, 1'b0, 32'h0, 32'h0, 1'b0, 32'd11, 1'b0});
    @(posedge clk); @(negedge clk);
    rst_n = 0; #1;
    check_zero_outputs("rst_add");
    sb.delete();
    repeat (2) begin @(negedge clk); check("rst_add_novalid", resp_valid, 0); end
    rst_n = 1;
    run_op('{1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'h9, 32'h9, 1'b0, 32'h0000_0030, 1'b0});

    start_op('{1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 1'b1});
    wait_resp(n);
    check("done_id", resp_id, 1);
    rst_n = 0; #1;
    check_zero_outputs("rst_done");
    sb.delete();
    @(negedge clk); rst_n = 1;
    run_op('{1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0003, 32'h0000_0004, 1'b1, 32'h0000_0007, 1'b0});

    @(negedge clk);
    w0_valid = 1; w0_a = 32'h8000_FFFF; w0_b = 32'h8000_0001;
    #1; check("w_ready0", w0_ready, 1);
    @(posedge clk); @(negedge clk);
    w0_valid = 0; w0_a = 0; w0_b = 0;
    n = 0;
    while (!w_resp_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    check("w_latency", n, 2);
    check("w_sum", w_resp_sum, 32'h0001_0000);
    check("w_cout", w_resp_cout, 1);
    check("w_id", w_resp_id, 0);
    w_resp_ready = 1;
    @(posedge clk); @(negedge clk);
    w_resp_ready = 0;
    check("w_idle", w_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adder_32bit_sched.md
ADDER_32BIT_SCHED -- requirements
Module: adder_32bit_sched

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 8: width of the single shared adder slice, and SHALL support only 8 and 16.
REQ-002 The block SHALL derive NSLICE = 32/SLICE_W as a localparam (4 at default).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0_valid, input, 1 bit, and req0_ready, output, 1 bit: requester 0 handshake.
REQ-006 The block SHALL have ports req0_a and req0_b, input, 32 bits each: requester 0 operands.
REQ-007 The block SHALL have ports req1_valid, input, 1 bit, and req1_ready, output, 1 bit: requester 1 handshake.
REQ-008 The block SHALL have ports req1_a and req1_b, input, 32 bits each: requester 1 operands.
REQ-009 The block SHALL have ports resp_valid, output, 1 bit, and resp_ready, input, 1 bit: result handshake.
REQ-010 The block SHALL have port resp_id, output, 1 bit: index of the requester that owns the result.
REQ-011 The block SHALL have port resp_sum, output, 32 bits: (a+b) mod 2^32.
REQ-012 The block SHALL have port resp_cout, output, 1 bit: carry out of bit 31.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-015 In IDLE, reqN_ready SHALL be driven combinationally high only for the granted requester; both ready signals SHALL be low in ADD and DONE.
REQ-016 Arbitration SHALL be round-robin: with one requester valid, that requester is granted; with both valid, the requester not served last is granted. The last-served pointer SHALL favour requester 0 after reset.
REQ-017 Acceptance (valid&&ready at a rising edge) SHALL latch a, b and resp_id, clear slice counter and carry, and move the FSM IDLE->ADD.
REQ-018 Each ADD cycle SHALL process slice k = counter, LSB first, as {carry, sum[k]} = a[k] + b[k] + carry, using exactly one SLICE_W-bit adder instance shared across all slices.
REQ-019 After processing slice NSLICE-1, the FSM SHALL move ADD->DONE; resp_valid SHALL be high exactly NSLICE rising edges after the acceptance edge.
REQ-020 In DONE, resp_valid, resp_id, resp_sum and resp_cout SHALL hold stable until resp_valid&&resp_ready; the FSM then SHALL move DONE->IDLE and update the last-served pointer.
REQ-021 The block SHALL NOT accept a new request in the same cycle that a response is consumed; minimum spacing between acceptances SHALL be NSLICE+2 cycles.
REQ-022 Input changes to reqN_a and reqN_b after acceptance SHALL NOT affect the result in progress.
REQ-023 A request that drops valid before acceptance SHALL be ignored with no state change.
REQ-024 Overflow SHALL wrap: resp_sum = (a+b) mod 2^32, with resp_cout carrying the lost bit.

Reset
REQ-025 Asserting rst_n low SHALL immediately force the following, regardless of FSM state: state=IDLE, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, busy=0, counter=0, carry=0, pointer favouring requester 0.
REQ-026 Reset asserted mid-ADD or in DONE SHALL discard the operation with no response emitted.
REQ-027 After rst_n deassertion, the block SHALL be ready to accept in the first IDLE cycle.

Verification
REQ-028 Single op on req0 with a=0x0000_00FF, b=0x0000_0001 -> resp_sum=0x0000_0100, cout=0, resp_id=0, resp_valid 4 edges after acceptance (SLICE_W=8).
REQ-029 Full carry ripple with a=0xFFFF_FFFF, b=0x0000_0001 -> resp_sum=0x0000_0000, cout=1.
REQ-030 Both requesters held valid continuously (req0 a=1,b=2; req1 a=3,b=4) -> grants alternate 0,1,0,1 with sums 3,7,3,7.
REQ-031 resp_ready held low for 10 cycles in DONE -> outputs stable, both ready signals low throughout; one cycle of resp_ready -> IDLE.
REQ-032 rst_n pulsed low during the 2nd ADD cycle -> no resp_valid, all outputs zero, next request completes correctly.
REQ-033 SLICE_W=16 with a=0x8000_FFFF, b=0x8000_0001 -> resp_sum=0x0001_0000, cout=1, latency 2 edges.
